// File: rtl/conf_int_mac__seq__arch_agnos.sv
// Sequential, precision-configurable signed integer multiply-accumulate unit.
// A run-time precision `prec` keeps only the top p operand bits (floor
// truncation). The product of the truncated operands is built one multiplier
// bit per cycle. It is then loaded into the accumulator or added to it.
// Ports:
//   clk, rst (sync, active-low)
//   in_valid / in_ready    : operand handshake (a, b, prec, acc__sel)
//   out_valid / out_ready  : result handshake; d is the accumulator value
module conf_int_mac__seq__arch_agnos #(
  parameter int unsigned DATA_PATH_BITWIDTH = 32,
  parameter int unsigned OP_BITWIDTH        = 32,
  parameter int unsigned PREC_W             = $clog2(DATA_PATH_BITWIDTH) + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]   a,
  input  logic [DATA_PATH_BITWIDTH-1:0]   b,
  input  logic [PREC_W-1:0]               prec,
  input  logic                            acc__sel,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*DATA_PATH_BITWIDTH-1:0] d
);

  localparam int unsigned DW = DATA_PATH_BITWIDTH;
  localparam int unsigned RW = 2 * DATA_PATH_BITWIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t            state;
  logic [RW-1:0]     acc;
  logic [RW-1:0]     prod;
  logic [RW-1:0]     mcand;
  logic [DW-1:0]     mplier;
  logic [PREC_W-1:0] cnt;
  logic              sel;

  logic [PREC_W-1:0] p_eff;
  logic [PREC_W-1:0] lsb;
  logic [DW-1:0]     keep;
  logic [DW-1:0]     at_t;
  logic [DW-1:0]     bt_t;
  logic [RW-1:0]     mcand_init;
  logic [DW-1:0]     mplier_init;
  logic              last;
  logic [RW-1:0]     term;
  logic [RW-1:0]     prod_next;
  logic [RW-1:0]     acc_next;

  // Effective precision: out-of-range requests (including 0) clamp to the maximum.
  always_comb begin
    p_eff = PREC_W'(OP_BITWIDTH);
    if (prec != '0 && prec <= PREC_W'(OP_BITWIDTH)) begin
      p_eff = prec;
    end
  end

  // Floor truncation: clear the low bits, then align the multiplier so that
  // bit L sits at position 0 and the multiplicand carries the 2^L weight.
  always_comb begin
    lsb         = PREC_W'(DW) - p_eff;
    keep        = {DW{1'b1}} << lsb;
    at_t        = a & keep;
    bt_t        = b & keep;
    mcand_init  = {{DW{at_t[DW-1]}}, at_t} << lsb;
    mplier_init = bt_t >> lsb;
  end

  // One shift-add step. The last step handles the multiplier sign bit, so its
  // term is subtracted, which keeps the signed product exact.
  always_comb begin
    last      = (cnt == PREC_W'(1));
    term      = mplier[0] ? mcand : '0;
    prod_next = last ? (prod - term) : (prod + term);
    acc_next  = sel ? (acc + prod_next) : prod_next;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      prod      <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      sel       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand    <= mcand_init;
            mplier   <= mplier_init;
            prod     <= '0;
            cnt      <= p_eff;
            sel      <= acc__sel;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          prod   <= prod_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - PREC_W'(1);
          if (last) begin
            acc       <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign d = acc;

endmodule
